// File: rtl/vga_bw_simple.sv
// Monochrome VGA timing generator: free-running pixel/line counters, a bordered
// checkerboard pattern, and registered active-low syncs aligned with the video bit.
module vga_bw_simple #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CHECK_LOG2 = 5
) (
    input  logic clk_25mhz,
    input  logic reset,
    output logic hsync,
    output logic vsync,
    output logic video
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_EDGE   = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_EDGE   = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       visible;
    logic       border;
    logic       hsync_d;
    logic       vsync_d;
    logic       video_d;

    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        border  = (h_cnt == '0) || (h_cnt == H_EDGE) || (v_cnt == '0) || (v_cnt == V_EDGE);
        hsync_d = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_d = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        video_d = 1'b0;
        if (visible) begin
            video_d = border ? 1'b1 : (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]);
        end
    end

    // Output register: all three outputs lag the counters by one clock together
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            video <= 1'b0;
        end else begin
            hsync <= hsync_d;
            vsync <= vsync_d;
            video <= video_d;
        end
    end

endmodule

// File: tb/tb_vga_bw_simple.sv
// Directed bench for vga_bw_simple using a reduced 80x55 timing so several frames fit
// in a short run; expected values are hand-derived from that timing.
module tb_vga_bw_simple;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 3;
    localparam int CL = 5;
    localparam int HT = HV + HF + HS + HB;   // 80
    localparam int VT = VV + VF + VS + VB;   // 55
    localparam int FRAME = HT * VT;          // 4400
    // border 2*64+2*48-4 = 220; checker interior 31*31 + 31*15 = 1426
    localparam int EXP_ONES = 1646;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hsync, vsync, video;

    int errors = 0;
    int checks = 0;

    vga_bw_simple #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CHECK_LOG2(CL)
    ) dut (
        .clk_25mhz(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .video(video)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent pixel model: {hsync, vsync, video} for counter position (h, v)
    function automatic logic [2:0] model(input int h, input int v);
        logic hs, vs, vid;
        hs = !(h >= HV + HF && h < HV + HF + HS);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        if (h >= HV || v >= VV) vid = 1'b0;
        else if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) vid = 1'b1;
        else vid = h[CL] ^ v[CL];
        return {hs, vs, vid};
    endfunction

    // Edges since reset release; sample at negedge after edge k shows pixel k-1
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic prev_hs, prev_vs;
    int hfall_n, hfall_first, hfall_last, hper_min, hper_max, hlow_min, hlow_max;
    int vfall_n, vfall_first, vfall_last, vper_min, vper_max, vlow_min, vlow_max;
    int mism;
    int vid_cnt [0:3];
    logic fbits [0:FRAME-1];

    always @(negedge clk) begin
        if (!reset) begin
            prev_hs <= 1'b1;  prev_vs <= 1'b1;
            hfall_n <= 0; hfall_first <= -1; hfall_last <= 0;
            hper_min <= 1000000000; hper_max <= 0; hlow_min <= 1000000000; hlow_max <= 0;
            vfall_n <= 0; vfall_first <= -1; vfall_last <= 0;
            vper_min <= 1000000000; vper_max <= 0; vlow_min <= 1000000000; vlow_max <= 0;
            mism <= 0;
            for (int i = 0; i < 4; i++) vid_cnt[i] <= 0;
        end else if (cyc > 0) begin
            prev_hs <= hsync;
            prev_vs <= vsync;
            if (prev_hs && !hsync) begin
                if (hfall_n == 0) hfall_first <= cyc;
                else begin
                    if (cyc - hfall_last < hper_min) hper_min <= cyc - hfall_last;
                    if (cyc - hfall_last > hper_max) hper_max <= cyc - hfall_last;
                end
                hfall_last <= cyc;
                hfall_n <= hfall_n + 1;
            end
            if (!prev_hs && hsync && hfall_n > 0) begin
                if (cyc - hfall_last < hlow_min) hlow_min <= cyc - hfall_last;
                if (cyc - hfall_last > hlow_max) hlow_max <= cyc - hfall_last;
            end
            if (prev_vs && !vsync) begin
                if (vfall_n == 0) vfall_first <= cyc;
                else begin
                    if (cyc - vfall_last < vper_min) vper_min <= cyc - vfall_last;
                    if (cyc - vfall_last > vper_max) vper_max <= cyc - vfall_last;
                end
                vfall_last <= cyc;
                vfall_n <= vfall_n + 1;
            end
            if (!prev_vs && vsync && vfall_n > 0) begin
                if (cyc - vfall_last < vlow_min) vlow_min <= cyc - vfall_last;
                if (cyc - vfall_last > vlow_max) vlow_max <= cyc - vfall_last;
            end
            if ({hsync, vsync, video} !== model((cyc - 1) % HT, ((cyc - 1) / HT) % VT))
                mism <= mism + 1;
            if (video && (cyc - 1) / FRAME < 4)
                vid_cnt[(cyc - 1) / FRAME] <= vid_cnt[(cyc - 1) / FRAME] + 1;
            if (cyc - 1 < FRAME)
                fbits[cyc - 1] <= video;
        end
    end

    function automatic int pix(input int h, input int v);
        return int'(fbits[v * HT + h]);
    endfunction

    initial begin
        bit found;
        // Reset held: outputs idle
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hsync", int'(hsync), 1);
        check_val("rst_vsync", int'(vsync), 1);
        check_val("rst_video", int'(video), 0);

        @(posedge clk); #10; reset = 1'b1;
        @(posedge clk); #1;
        check_val("first_hsync", int'(hsync), 1);
        check_val("first_vsync", int'(vsync), 1);
        check_val("first_video", int'(video), 1);

        repeat (3 * FRAME + 100) @(posedge clk);
        @(negedge clk); #1;

        check_val("hfall_first", hfall_first, HV + HF + 1);
        check_val("hper_min", hper_min, HT);
        check_val("hper_max", hper_max, HT);
        check_val("hlow_min", hlow_min, HS);
        check_val("hlow_max", hlow_max, HS);
        check_val("vfall_first", vfall_first, (VV + VF) * HT + 1);
        check_val("vfall_n", vfall_n, 3);
        check_val("vper_min", vper_min, FRAME);
        check_val("vper_max", vper_max, FRAME);
        check_val("vlow_min", vlow_min, VS * HT);
        check_val("vlow_max", vlow_max, VS * HT);
        check_val("model_mism", mism, 0);
        check_val("ones_f0", vid_cnt[0], EXP_ONES);
        check_val("ones_f1", vid_cnt[1], EXP_ONES);
        check_val("ones_f2", vid_cnt[2], EXP_ONES);

        check_val("px_0_0", pix(0, 0), 1);
        check_val("px_70_5", pix(70, 5), 0);
        check_val("px_79_20", pix(79, 20), 0);
        check_val("px_10_50", pix(10, 50), 0);
        check_val("px_32_1", pix(32, 1), 1);
        check_val("px_32_32", pix(32, 32), 0);
        check_val("px_1_1", pix(1, 1), 0);
        check_val("px_63_10", pix(63, 10), 1);
        check_val("px_20_47", pix(20, 47), 1);

        // Mid-frame reset on line 20 while hsync is low
        found = 1'b0;
        for (int i = 0; i < FRAME + HT; i++) begin
            @(negedge clk);
            if ((cyc - 1) % FRAME == 20 * HT + HV + HF + 2) begin
                found = 1'b1;
                break;
            end
        end
        check_val("midrst_found", int'(found), 1);
        check_val("midrst_pre_hs", int'(hsync), 0);
        @(posedge clk); #5; reset = 1'b0; #1;
        check_val("midrst_hsync", int'(hsync), 1);
        check_val("midrst_vsync", int'(vsync), 1);
        check_val("midrst_video", int'(video), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_hold_hs", int'(hsync), 1);
        @(posedge clk); #10; reset = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 2 * HT; i++) begin
            @(negedge clk); #1;
            if (hfall_n > 0) begin
                found = 1'b1;
                break;
            end
        end
        check_val("post_rst_hfall_seen", int'(found), 1);
        check_val("post_rst_hfall", hfall_first, HV + HF + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_bw_simple.md
VGA_BW_SIMPLE -- requirements
Module: vga_bw_simple

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch; H_TOTAL = sum of H_* = 800.
REQ-005 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch; V_TOTAL = sum of V_* = 525.
REQ-009 Parameter CHECK_LOG2, default 5: checkerboard square size = 2^CHECK_LOG2 pixels.
REQ-010 clk_25mhz  input  1  pixel clock, 25 MHz nominal; all state changes on its rising edge.
REQ-011 reset  input  1  asynchronous, active-low reset.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 video  output  1  monochrome pixel: 1 = white, 0 = black.

Function
REQ-015 Internal h_cnt counts 0..H_TOTAL-1 and increments by 1 every clock.
REQ-016 When h_cnt = H_TOTAL-1, h_cnt wraps to 0 on the next clock, and v_cnt increments.
REQ-017 v_cnt counts 0..V_TOTAL-1 and wraps to 0 after V_TOTAL-1 when h_cnt also wraps.
REQ-018 Counter widths: h_cnt 10 bits, v_cnt 10 bits; neither counter ever exceeds its TOTAL-1.
REQ-019 One frame = 800 x 525 = 420000 clocks (16.8 ms at 25 MHz).
REQ-020 Visible region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-021 hsync decode = 0 exactly when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise 1.
REQ-022 vsync decode = 0 exactly when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491); otherwise 1.
REQ-023 video decode is 0 outside the visible region.
REQ-024 Inside the visible region, video decode is 1 on the border: h_cnt = 0, h_cnt = H_VISIBLE-1, v_cnt = 0, or v_cnt = V_VISIBLE-1.
REQ-025 Elsewhere in the visible region, video decode = h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2].
REQ-026 hsync, vsync and video are registered.
REQ-027 Each output at clock edge t reflects the decode of the counter values held before edge t (1-cycle latency); all three outputs stay mutually aligned.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 While reset = 0: h_cnt = 0, v_cnt = 0, hsync = 1, vsync = 1, video = 0, applied immediately without waiting for a clock.
REQ-030 On the first rising edge after reset deasserts, h_cnt becomes 1, and the outputs show the decode of (0,0): hsync = 1, vsync = 1, video = 1.
REQ-031 Reset asserted mid-frame aborts the frame; counting restarts from (0,0) after release, with no partial sync pulse held.

Verification
REQ-032 Scenario: release reset and run 3 frames -> exactly 800 clocks between successive hsync falling edges; exactly 420000 clocks between vsync falling edges.
REQ-033 Scenario: per line -> hsync is low for exactly 96 clocks; its falling edge occurs 657 clocks after the first clock of the line, including the 1-cycle latency.
REQ-034 Scenario: per frame -> vsync is low for exactly 2 x 800 = 1600 clocks, starting at line 490.
REQ-035 Scenario: sample video -> pixel (0,0) = 1; (640..799, any line) = 0; (any pixel, line 480..524) = 0; (32,1) = 1; (32,32) = 0; (1,1) = 0.
REQ-036 Scenario: assert reset at line 200 -> outputs are 1/1/0 with no clock edge; after release, the next hsync falling edge occurs 657 clocks later.
REQ-037 Scenario: count video = 1 pixels over one full frame -> the count equals the border pixels plus the checkerboard pixels computed by a reference model; the count is identical every frame.
